binary_search_ctrl: RTL and testbench

//  FSM+datapath controller for the lab 4 task 2 binary search.

---
 rtl/lab4_pkg.sv | 15 +
 rtl/bsearch_datapath.sv | 63 ++++++
 rtl/binary_search_ctrl.sv | 128 ++++++++++++
 tb/tb_binary_search_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab4_pkg.sv
// Shared types and default sizes for the lab 4 binary search block.
package lab4_pkg;

  localparam int unsigned BS_ADDR_W = 5;
  localparam int unsigned BS_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    WAIT = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } bs_state_t;

endpackage

// File: rtl/bsearch_datapath.sv
// Search-window registers (low/high/mid), captured target and compare flags.
module bsearch_datapath #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              load_i,
  input  logic              calc_i,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic [DATA_W-1:0] target_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [ADDR_W:0]   mid_o,
  output logic              eq_o,
  output logic              lt_o,
  output logic              at_low_o,
  output logic              at_high_o
);

  // One spare bit so low+high and mid+1 never overflow.
  localparam logic [ADDR_W:0] TopAddr = {1'b0, {ADDR_W{1'b1}}};

  logic [ADDR_W:0]   low_q, low_d, high_q, high_d, mid_q, mid_d, sum;
  logic [DATA_W-1:0] target_q, target_d;

  always_comb begin
    sum      = low_q + high_q;
    low_d    = low_q;
    high_d   = high_q;
    mid_d    = mid_q;
    target_d = target_q;
    if (load_i) begin
      low_d    = '0;
      high_d   = TopAddr;
      target_d = target_i;
    end
    if (calc_i) mid_d = sum >> 1;
    if (inc_i)  low_d = mid_q + 1'b1;
    if (dec_i)  high_d = mid_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      low_q    <= '0;
      high_q   <= TopAddr;
      mid_q    <= '0;
      target_q <= '0;
    end else begin
      low_q    <= low_d;
      high_q   <= high_d;
      mid_q    <= mid_d;
      target_q <= target_d;
    end
  end

  assign mid_o     = mid_q;
  assign eq_o      = (rdata_i == target_q);
  assign lt_o      = (rdata_i < target_q);
  assign at_low_o  = (mid_q == low_q);
  assign at_high_o = (mid_q == high_q);

endmodule

// File: rtl/binary_search_ctrl.sv
// Binary search over a sorted synchronous RAM: control FSM, read-latency wait
// counter and result registers around bsearch_datapath.
module binary_search_ctrl
  import lab4_pkg::*;
#(
  parameter int unsigned ADDR_W  = BS_ADDR_W,
  parameter int unsigned DATA_W  = BS_DATA_W,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] target,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] loc,
  output logic              found,
  output logic              done
);

  localparam int unsigned CntW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RAM_LAT - 1);

  bs_state_t         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] loc_q, loc_d;
  logic              found_q, found_d, done_q, done_d;
  logic              load, calc, inc, dec;
  logic [ADDR_W:0]   mid;
  logic              eq, lt, at_low, at_high;

  bsearch_datapath #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_datapath (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .load_i   (load),
    .calc_i   (calc),
    .inc_i    (inc),
    .dec_i    (dec),
    .target_i (target),
    .rdata_i  (ram_rdata),
    .mid_o    (mid),
    .eq_o     (eq),
    .lt_o     (lt),
    .at_low_o (at_low),
    .at_high_o(at_high)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loc_d   = loc_q;
    found_d = found_q;
    done_d  = done_q;
    load    = 1'b0;
    calc    = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          found_d = 1'b0;
          done_d  = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        calc    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CntLast) state_d = CMP;
        else cnt_d = cnt_q + CntW'(1);
      end
      CMP: begin
        // Edge-of-window checks stop the search before low/high leave the array.
        if (eq) begin
          loc_d   = mid[ADDR_W-1:0];
          found_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if ((lt && at_high) || (!lt && at_low)) begin
          loc_d   = '0;
          found_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          inc     = lt;
          dec     = !lt;
          state_d = CALC;
        end
      end
      DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      loc_q   <= '0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loc_q   <= loc_d;
      found_q <= found_d;
      done_q  <= done_d;
    end
  end

  assign ram_addr = mid[ADDR_W-1:0];
  assign loc      = loc_q;
  assign found    = found_q;
  assign done     = done_q;

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Bench: two controllers (RAM latency 1 and 2) share stimulus over one memory image.
module tb_binary_search_ctrl;

  typedef struct {
    logic [7:0] tgt;
    logic       exp_found;
    logic [4:0] exp_loc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       start;
  logic [7:0] target;
  logic [4:0] addr_w [2];
  logic [4:0] loc_w [2];
  logic [7:0] rdata_w [2];
  logic       found_w [2];
  logic       done_w [2];
  logic [7:0] mem [32];
  logic [7:0] pipe1;

  int n_chk = 0;
  int n_pass = 0;
  int done_cyc [2];
  logic       res_found [2];
  logic [4:0] res_loc [2];
  int tr0[$], tr1[$], tc0[$], tc1[$];

  binary_search_ctrl #(.ADDR_W(5), .DATA_W(8), .RAM_LAT(1)) u_dut0 (
    .clk(clk), .reset_n(rst_n[0]), .start(start), .target(target),
    .ram_addr(addr_w[0]), .ram_rdata(rdata_w[0]), .loc(loc_w[0]),
    .found(found_w[0]), .done(done_w[0])
  );

  binary_search_ctrl #(.ADDR_W(5), .DATA_W(8), .RAM_LAT(2)) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]), .start(start), .target(target),
    .ram_addr(addr_w[1]), .ram_rdata(rdata_w[1]), .loc(loc_w[1]),
    .found(found_w[1]), .done(done_w[1])
  );

  always_ff @(posedge clk) rdata_w[0] <= mem[addr_w[0]];
  always_ff @(posedge clk) begin
    pipe1      <= mem[addr_w[1]];
    rdata_w[1] <= pipe1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: the target's location in a strictly increasing array, if present.
  function automatic void ref_search(input logic [7:0] t, output logic f, output logic [4:0] l);
    f = 1'b0;
    l = '0;
    for (int i = 0; i < 32; i++) begin
      if (mem[i] == t) begin
        f = 1'b1;
        l = 5'(i);
      end
    end
  endfunction

  task automatic run_search(input logic [7:0] t, input bit pulse, input bit chg);
    int cyc;
    bit fin [2];
    logic [4:0] last [2];
    cyc = 0;
    fin[0] = 1'b0;
    fin[1] = 1'b0;
    done_cyc[0] = 0;
    done_cyc[1] = 0;
    tr0.delete(); tr1.delete(); tc0.delete(); tc1.delete();
    last[0] = addr_w[0];
    last[1] = addr_w[1];
    target = t;
    start = 1'b1;
    while (!(fin[0] && fin[1]) && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pulse) start = 1'b0;
      if (chg && cyc == 4) target = ~t;
      if (addr_w[0] != last[0]) begin
        tr0.push_back(int'(addr_w[0])); tc0.push_back(cyc); last[0] = addr_w[0];
      end
      if (addr_w[1] != last[1]) begin
        tr1.push_back(int'(addr_w[1])); tc1.push_back(cyc); last[1] = addr_w[1];
      end
      for (int k = 0; k < 2; k++) begin
        if (!fin[k] && done_w[k]) begin
          fin[k] = 1'b1;
          done_cyc[k] = cyc;
          res_found[k] = found_w[k];
          res_loc[k] = loc_w[k];
        end
      end
    end
    chk("done_within_budget", {31'd0, fin[0] && fin[1]}, 32'd1);
  endtask

  task automatic check_result(input string name, input logic ef, input logic [4:0] el);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_found_lat%0d", name, k + 1), {31'd0, res_found[k]}, {31'd0, ef});
      chk($sformatf("%s_loc_lat%0d", name, k + 1), {27'd0, res_loc[k]}, {27'd0, el});
      chk($sformatf("%s_cycles_lat%0d", name, k + 1),
          {31'd0, done_cyc[k] <= 1 + 6 * (k + 3)}, 32'd1);
    end
  endtask

  task automatic release_start(input string name, input logic ef, input logic [4:0] el);
    start = 1'b0;
    step(2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_done_clr_lat%0d", name, k + 1), {31'd0, done_w[k]}, 32'd0);
      chk($sformatf("%s_found_hold_lat%0d", name, k + 1), {31'd0, found_w[k]}, {31'd0, ef});
      chk($sformatf("%s_loc_hold_lat%0d", name, k + 1), {27'd0, loc_w[k]}, {27'd0, el});
    end
  endtask

  task automatic check_zero(input int k, input string name);
    chk({name, "_addr"}, {27'd0, addr_w[k]}, 32'd0);
    chk({name, "_loc"}, {27'd0, loc_w[k]}, 32'd0);
    chk({name, "_found"}, {31'd0, found_w[k]}, 32'd0);
    chk({name, "_done"}, {31'd0, done_w[k]}, 32'd0);
  endtask

  vec_t vecs [10];
  int exp_trace [5];
  logic [4:0] held_addr [2];

  initial begin
    logic rf;
    logic [4:0] rl;
    int v;
    logic [7:0] t;

    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);
    vecs[0] = '{8'd20,  1'b1, 5'd10};
    vecs[1] = '{8'd0,   1'b1, 5'd0};
    vecs[2] = '{8'd62,  1'b1, 5'd31};
    vecs[3] = '{8'd21,  1'b0, 5'd0};
    vecs[4] = '{8'd255, 1'b0, 5'd0};
    vecs[5] = '{8'd40,  1'b1, 5'd20};
    vecs[6] = '{8'd6,   1'b1, 5'd3};
    vecs[7] = '{8'd1,   1'b0, 5'd0};
    vecs[8] = '{8'd61,  1'b0, 5'd0};
    vecs[9] = '{8'd30,  1'b1, 5'd15};
    exp_trace = '{15, 7, 11, 9, 10};

    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    start = 1'b0;
    target = 8'd0;
    step(2);
    check_zero(0, "reset_lat1");
    check_zero(1, "reset_lat2");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    step(1);

    // Pulsed start from a fresh reset: probe order, probe period and latency.
    run_search(8'd20, 1'b1, 1'b0);
    check_result("t20_pulse", 1'b1, 5'd10);
    chk("trace_len_lat1", tr0.size(), 5);
    chk("trace_len_lat2", tr1.size(), 5);
    for (int i = 0; i < 5 && i < tr0.size() && i < tr1.size(); i++) begin
      chk($sformatf("trace%0d_lat1", i), tr0[i], exp_trace[i]);
      chk($sformatf("trace%0d_lat2", i), tr1[i], exp_trace[i]);
      if (i > 0) begin
        chk($sformatf("period%0d_lat1", i), tc0[i] - tc0[i-1], 3);
        chk($sformatf("period%0d_lat2", i), tc1[i] - tc1[i-1], 4);
      end
    end
    chk("t20_exact_cycles_lat1", done_cyc[0], 1 + 5 * 3);
    chk("t20_exact_cycles_lat2", done_cyc[1], 1 + 5 * 4);
    step(2);

    for (int i = 0; i < 10; i++) begin
      run_search(vecs[i].tgt, 1'b0, 1'b0);
      check_result($sformatf("vec%0d", i), vecs[i].exp_found, vecs[i].exp_loc);
      for (int k = 0; k < 2; k++)
        chk($sformatf("vec%0d_no_wrap_lat%0d", i, k + 1),
            {31'd0, (k == 0 ? tr0.size() : tr1.size()) <= 6}, 32'd1);
      release_start($sformatf("vec%0d", i), vecs[i].exp_found, vecs[i].exp_loc);
    end

    // Start held through DONE must not trigger another search.
    run_search(8'd62, 1'b0, 1'b0);
    held_addr[0] = addr_w[0];
    held_addr[1] = addr_w[1];
    step(8);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("hold_done_lat%0d", k + 1), {31'd0, done_w[k]}, 32'd1);
      chk($sformatf("hold_addr_lat%0d", k + 1), {27'd0, addr_w[k]}, {27'd0, held_addr[k]});
    end
    release_start("hold", 1'b1, 5'd31);
    run_search(8'd40, 1'b0, 1'b0);
    check_result("after_hold", 1'b1, 5'd20);
    release_start("after_hold", 1'b1, 5'd20);

    // Reset in the WAIT state of the third probe (edge 8 for lat 1, edge 10 for lat 2).
    target = 8'd20;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    rst_n[0] = 1'b0;
    step(1);
    check_zero(0, "midreset_lat1");
    rst_n[0] = 1'b1;
    step(1);
    rst_n[1] = 1'b0;
    step(1);
    check_zero(1, "midreset_lat2");
    chk("midreset_idle_lat1", {27'd0, addr_w[0]}, 32'd0);
    rst_n[1] = 1'b1;
    step(2);
    check_zero(0, "post_reset_idle_lat1");
    run_search(8'd6, 1'b0, 1'b0);
    check_result("after_reset", 1'b1, 5'd3);
    release_start("after_reset", 1'b1, 5'd3);

    // Target changes mid-search; the captured value must win.
    run_search(8'd20, 1'b0, 1'b1);
    check_result("target_change", 1'b1, 5'd10);
    release_start("target_change", 1'b1, 5'd10);

    // Random strictly increasing memories and random targets.
    for (int it = 0; it < 30; it++) begin
      v = $urandom_range(0, 20);
      for (int i = 0; i < 32; i++) begin
        mem[i] = 8'(v);
        v += $urandom_range(1, 7);
      end
      if ($urandom_range(0, 1) == 1) t = mem[$urandom_range(0, 31)];
      else t = 8'($urandom_range(0, 255));
      ref_search(t, rf, rl);
      run_search(t, $urandom_range(0, 1) == 1, 1'b0);
      check_result($sformatf("rand%0d", it), rf, rl);
      release_start($sformatf("rand%0d", it), rf, rl);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
